rf_mp: RTL
==========

// Module: rf_mp
// PURPOSE
// - Parametrised multi-port CPU register file; successor to the single-port 8-bit file.
// - Serves the NES-CPU datapath with NUM_RD combinational read ports and one write port.
// - Write port supports 16-bit pair writes (e.g. PCL/PCH).
// - Adds a dedicated stack pointer with hardware push/pop stepping.
// - Adds a status register (P) with per-bit flag masking, plus a sticky error flag.
// PARAMETERS
// - NUM_REGS  6      number of DATA_W-bit registers; AW = $clog2(NUM_REGS)
// - DATA_W    8      register width in bits
// - NUM_RD    2      number of independent read ports
// - SP_IDX    3      index of the stack pointer register
// - P_IDX     4      index of the status register
// - SP_RST    8'hFD  reset value of SP (resized to DATA_W)
// - P_RST     8'h34  reset value of P (resized to DATA_W)
// - BYPASS    1      1 = write-port data forwarded to same-cycle reads
// PORTS
// - clk_i        in   1               clock, rising edge
// - rstn_i       in   1               reset; asynchronous, active-low
// - rd_addr_i    in   NUM_RD*AW       read addresses, port k at [k*AW +: AW]
// - rd_data_o    out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
// - wr_en_i      in   1               write-port enable
// - wr_pair_i    in   1               1 = 2*DATA_W pair write to wr_addr_i and wr_addr_i+1
// - wr_addr_i    in   AW              write address (low register of a pair)
// - wr_data_i    in   2*DATA_W        write data; single write uses [DATA_W-1:0]
// - sp_op_i      in   2               00 none, 01 push (SP-1), 10 pop (SP+1), 11 none
// - flag_we_i    in   DATA_W          per-bit write mask into P
// - flag_data_i  in   DATA_W          flag values, applied where the mask bit is 1
// - sp_o         out  DATA_W          current SP
// - p_o          out  DATA_W          current P
// - sp_wrap_o    out  1               one-cycle pulse: the previous cycle's SP step wrapped
// - wr_err_o     out  1               sticky illegal-write flag
// BEHAVIOUR
// - Reset (rstn_i=0, async):
//   - All registers clear to 0, except SP=SP_RST and P=P_RST.
//   - sp_wrap_o=0, wr_err_o=0. Bypass is disabled, so rd_data_o shows stored reset values.
//   - All writes are ignored while rstn_i=0.
// - Reads: combinational from stored state.
//   - An address >= NUM_REGS reads 0.
//   - Ports are fully independent; the same address on several ports is allowed.
// - Write port: committed on the clock edge.
//   - Single write: reg[wr_addr_i] <= wr_data_i[DATA_W-1:0].
//   - Pair write: reg[a] <= low half; reg[a+1] <= high half.
// - Bypass (BYPASS=1, rstn_i=1, wr_en_i=1):
//   - A read of a register being written this cycle by the write port returns the new value (0-cycle latency).
//   - SP-step and flag updates are never bypassed; they are visible the cycle after the edge.
// - BYPASS=0: every write is visible on rd_data_o one cycle after the edge.
// - Illegal write: wr_addr_i >= NUM_REGS, or pair write with wr_addr_i+1 >= NUM_REGS.
//   - The whole write is dropped (no partial pair); wr_err_o <= 1 and holds until reset.
// - SP stepping: modulo 2^DATA_W.
//   - Push from 0 -> all-ones; pop from all-ones -> 0.
//   - Either wrap sets sp_wrap_o=1 for exactly the next cycle.
// - Priority on SP: a legal write-port write touching SP_IDX wins; sp_op_i is ignored that cycle (no wrap pulse).
// - Priority on P: the write-port value is taken first; then bits with flag_we_i=1 are overwritten by flag_data_i.
//   - Net result: P <= (wr ? wdata : P) & ~mask | flag_data_i & mask.
// - sp_o and p_o always equal the stored SP and P (no bypass).
// - Reset asserted mid-operation: state returns to reset values immediately; no pending write survives.
// TESTING
// - Reset check: rstn_i low, then released.
//   - Expect sp_o=FD, p_o=34, every other register reads 00, wr_err_o=0, sp_wrap_o=0.
// - Bypass: write A5 to reg0 while rd_addr port0=0, port1=1.
//   - Same cycle: port0=A5, port1=00. Repeat with BYPASS=0: port0=A5 only on the next cycle.
// - Pair write: addr=0, data=BEEF.
//   - Expect reg0=EF, reg1=BE.
//   - Then pair write at addr=5 with NUM_REGS=6: no register changes, wr_err_o=1 and stays 1.
// - SP wrap: write SP=00, then push.
//   - Expect sp_o=FF and sp_wrap_o high for exactly 1 cycle.
//   - Pop -> 00 with a 1-cycle pulse. Push concurrent with a write of 40 to SP -> sp_o=40, no pulse.
// - Flags: P=34; wr_en write 00 to P with flag_we=01, flag_data=01 in the same cycle.
//   - Expect p_o=01.
//   - Then flag_we=80, flag_data=80 alone -> p_o=81.
// - Async reset mid-pair-write: rstn_i drops between clock edges.
//   - Registers return to reset values at once; the pending write is not committed on the next edge.

Source files
------------

// File: rtl/rf_mp.sv
// Multi-port CPU register file: NUM_RD combinational read ports, one single/pair write port,
// a stack pointer with push/pop stepping, and a status register with per-bit flag masking.
module rf_mp #(
  parameter int unsigned       NUM_REGS = 6,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       NUM_RD   = 2,
  parameter int unsigned       SP_IDX   = 3,
  parameter int unsigned       P_IDX    = 4,
  parameter logic [DATA_W-1:0] SP_RST   = DATA_W'(8'hFD),
  parameter logic [DATA_W-1:0] P_RST    = DATA_W'(8'h34),
  parameter bit                BYPASS   = 1'b1,
  localparam int unsigned      AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic                     wr_pair_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [2*DATA_W-1:0]      wr_data_i,
  input  logic [1:0]               sp_op_i,
  input  logic [DATA_W-1:0]        flag_we_i,
  input  logic [DATA_W-1:0]        flag_data_i,
  output logic [DATA_W-1:0]        sp_o,
  output logic [DATA_W-1:0]        p_o,
  output logic                     sp_wrap_o,
  output logic                     wr_err_o
);

  localparam logic [AW:0] NRegs = (AW+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] wr_val [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [AW:0]       addr_lo, addr_hi;
  logic              wr_ok;
  logic              sp_wrap_q, sp_wrap_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] sp_cur;

  assign sp_cur = regs_q[SP_IDX];

  // Write decode: a pair is legal only if both halves land inside the file.
  always_comb begin
    addr_lo = {1'b0, wr_addr_i};
    addr_hi = addr_lo + (AW+1)'(1);
    wr_ok   = wr_en_i && (addr_lo < NRegs) && (!wr_pair_i || (addr_hi < NRegs));
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = 1'b0;
      wr_val[i] = '0;
      if (wr_ok && (addr_lo == (AW+1)'(i))) begin
        wr_hit[i] = 1'b1;
        wr_val[i] = wr_data_i[DATA_W-1:0];
      end else if (wr_ok && wr_pair_i && (addr_hi == (AW+1)'(i))) begin
        wr_hit[i] = 1'b1;
        wr_val[i] = wr_data_i[2*DATA_W-1:DATA_W];
      end
    end
  end

  always_comb begin
    regs_d    = regs_q;
    sp_wrap_d = 1'b0;
    wr_err_d  = wr_err_q | (wr_en_i & ~wr_ok);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit[i]) regs_d[i] = wr_val[i];
    end
    // A write-port write to SP overrides any push/pop in the same cycle.
    if (!wr_hit[SP_IDX]) begin
      if (sp_op_i == 2'b01) begin
        regs_d[SP_IDX] = sp_cur - DATA_W'(1);
        sp_wrap_d      = (sp_cur == '0);
      end else if (sp_op_i == 2'b10) begin
        regs_d[SP_IDX] = sp_cur + DATA_W'(1);
        sp_wrap_d      = (sp_cur == '1);
      end
    end
    regs_d[P_IDX] = (regs_d[P_IDX] & ~flag_we_i) | (flag_data_i & flag_we_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == SP_IDX)     regs_q[i] <= SP_RST;
        else if (i == P_IDX) regs_q[i] <= P_RST;
        else                 regs_q[i] <= '0;
      end
      sp_wrap_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      sp_wrap_q <= sp_wrap_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Out-of-range addresses match no register and read 0.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr_i[k*AW +: AW] == AW'(i)) begin
          if (BYPASS && rstn_i && wr_hit[i]) rd_data_o[k*DATA_W +: DATA_W] = wr_val[i];
          else                               rd_data_o[k*DATA_W +: DATA_W] = regs_q[i];
        end
      end
    end
  end

  assign sp_o      = regs_q[SP_IDX];
  assign p_o       = regs_q[P_IDX];
  assign sp_wrap_o = sp_wrap_q;
  assign wr_err_o  = wr_err_q;

endmodule
